// File: rtl/nim_trigger_logic.sv
// Majority coincidence trigger for conditioned NIM channels: per-channel hit windows,
// veto/enable gating, fixed-width output pulse, dead time and saturating trigger counters.
module nim_trigger_logic #(
   parameter int N_CH  = 8,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_CH-1:0]  ch_in,
   input  logic [N_CH-1:0]  ch_mask,
   input  logic [3:0]       majority,
   input  logic [7:0]       window,
   input  logic [7:0]       out_width,
   input  logic [15:0]      deadtime,
   input  logic             veto,
   input  logic             enable,
   input  logic             count_clear,
   output logic             trig_out,
   output logic             busy,
   output logic [CNT_W-1:0] trig_count,
   output logic [CNT_W-1:0] lost_count,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FIRE = 2'd1,
      DEAD = 2'd2
   } state_t;

   state_t                  state, state_n;
   logic [15:0]             cnt, cnt_n;
   logic [N_CH-1:0]         d1, d2, rise_q;
   logic [N_CH-1:0][7:0]    timer;
   logic [N_CH-1:0]         active;
   logic [7:0]              hit_cnt;
   logic [7:0]              window_eff, width_eff;
   logic                    coinc;
   logic                    idle_eval, clr_timers, trig_inc, lost_inc;

   assign window_eff = (window == 8'd0) ? 8'd1 : window;
   assign width_eff  = (out_width == 8'd0) ? 8'd1 : out_width;
   assign state_dbg  = state;

   // Rising edge is registered once more so the hit timers load from a flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d1     <= '0;
         d2     <= '0;
         rise_q <= '0;
      end else begin
         d1     <= ch_in;
         d2     <= d1;
         rise_q <= d1 & ~d2;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timer <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (!enable || clr_timers)
               timer[i] <= 8'd0;
            else if (rise_q[i])
               timer[i] <= window_eff;
            else if (timer[i] != 8'd0)
               timer[i] <= timer[i] - 8'd1;
         end
      end
   end

   always_comb begin
      active  = '0;
      hit_cnt = 8'd0;
      for (int i = 0; i < N_CH; i++) begin
         active[i] = (timer[i] != 8'd0);
         hit_cnt   = hit_cnt + 8'(active[i] & ch_mask[i]);
      end
      coinc = (majority != 4'd0) && (hit_cnt >= {4'd0, majority});
   end

   // Leaving FIRE/DEAD evaluates the idle decision in the same cycle, so a pending
   // coincidence refires with spacing of exactly out_width_eff + deadtime.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      idle_eval  = 1'b0;
      clr_timers = 1'b0;
      trig_inc   = 1'b0;
      lost_inc   = 1'b0;
      case (state)
         IDLE: idle_eval = 1'b1;
         FIRE: begin
            if (cnt != 16'd0) begin
               cnt_n = cnt - 16'd1;
            end else if (deadtime != 16'd0) begin
               state_n = DEAD;
               cnt_n   = deadtime - 16'd1;
            end else begin
               state_n   = IDLE;
               idle_eval = 1'b1;
            end
         end
         DEAD: begin
            if (cnt != 16'd0) begin
               cnt_n = cnt - 16'd1;
            end else begin
               state_n   = IDLE;
               idle_eval = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      if (idle_eval && enable && coinc) begin
         clr_timers = 1'b1;
         if (!veto) begin
            state_n  = FIRE;
            cnt_n    = {8'd0, width_eff - 8'd1};
            trig_inc = 1'b1;
         end else begin
            lost_inc = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 16'd0;
         trig_out <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         trig_out <= (state_n == FIRE);
         busy     <= (state_n != IDLE);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trig_count <= '0;
         lost_count <= '0;
      end else if (count_clear) begin
         trig_count <= '0;
         lost_count <= '0;
      end else begin
         if (trig_inc && (trig_count != '1))
            trig_count <= trig_count + CNT_W'(1);
         if (lost_inc && (lost_count != '1))
            lost_count <= lost_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_nim_trigger_logic.sv
// Bench for nim_trigger_logic: vector table of single-shot scenarios plus hand-written
// multi-cycle sequences; expected trigger cycles are queued and matched on trig_out rise.
module tb_nim_trigger_logic;

   localparam int N_CH  = 8;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [N_CH-1:0]  ch_in;
   logic [N_CH-1:0]  ch_mask;
   logic [3:0]       majority;
   logic [7:0]       window;
   logic [7:0]       out_width;
   logic [15:0]      deadtime;
   logic             veto;
   logic             enable;
   logic             count_clear;
   logic             trig_out;
   logic             busy;
   logic [CNT_W-1:0] trig_count;
   logic [CNT_W-1:0] lost_count;
   logic [1:0]       state_dbg;

   always #5 clk = ~clk;

   nim_trigger_logic #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .ch_in(ch_in), .ch_mask(ch_mask), .majority(majority),
      .window(window), .out_width(out_width), .deadtime(deadtime), .veto(veto),
      .enable(enable), .count_clear(count_clear), .trig_out(trig_out), .busy(busy),
      .trig_count(trig_count), .lost_count(lost_count), .state_dbg(state_dbg)
   );

   typedef struct {
      logic        en;
      logic        vt;
      logic [7:0]  mask;
      logic [3:0]  maj;
      logic [7:0]  win;
      logic [7:0]  wid;
      logic [15:0] dead;
      int ch_a, t_a, ch_b, t_b, ch_c, t_c;
      int fire, hi, bsy, trg, lst;
   } vec_t;

   vec_t        vecs[14];
   logic [31:0] exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc, hi_cnt, busy_cnt;
   logic        trig_prev;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
      end
   endtask

   task automatic do_reset(input logic hold);
      reset = 1'b1;
      ch_in = hold ? 8'h01 : 8'h00;
      enable = 1'b0; veto = 1'b0; count_clear = 1'b0;
      ch_mask = '0; majority = '0; window = '0; out_width = '0; deadtime = '0;
      #1;
      chk("rst_trig_out", 32'(trig_out), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_trig_count", 32'(trig_count), 0);
      chk("rst_lost_count", 32'(lost_count), 0);
      chk("rst_state", 32'(state_dbg), 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc = 0; hi_cnt = 0; busy_cnt = 0; trig_prev = 1'b0;
      exp_q.delete();
   endtask

   task automatic tick();
      logic [31:0] e;
      @(posedge clk);
      #1;
      if (trig_out && !trig_prev) begin
         if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_trigger cycle=%0d expected=none", cyc);
         end else begin
            e = exp_q.pop_front();
            chk("fire_cycle", 32'(cyc), e);
         end
      end
      hi_cnt   += int'(trig_out);
      busy_cnt += int'(busy);
      trig_prev = trig_out;
      cyc++;
   endtask

   task automatic check_end(input string tag, input int hi, input int bsy, input int trg,
                            input int lst);
      chk({tag, "_hi_cycles"}, 32'(hi_cnt), 32'(hi));
      chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(bsy));
      chk({tag, "_trig_count"}, 32'(trig_count), 32'(trg));
      chk({tag, "_lost_count"}, 32'(lost_count), 32'(lst));
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_missing_trigger pending=%0d expected=0", tag, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic config_set(input logic [7:0] m, input logic [3:0] mj, input logic [7:0] w,
                             input logic [7:0] wd, input logic [15:0] dt);
      enable = 1'b1; veto = 1'b0;
      ch_mask = m; majority = mj; window = w; out_width = wd; deadtime = dt;
   endtask

   task automatic run_vec(input int k);
      vec_t v;
      v = vecs[k];
      do_reset(1'b0);
      config_set(v.mask, v.maj, v.win, v.wid, v.dead);
      enable = v.en;
      veto   = v.vt;
      for (int c = 0; c < 40; c++) begin
         ch_in = '0;
         if (c == v.t_a) ch_in[v.ch_a] = 1'b1;
         if (c == v.t_b) ch_in[v.ch_b] = 1'b1;
         if (c == v.t_c) ch_in[v.ch_c] = 1'b1;
         if (c == v.t_a && v.fire >= 0) exp_q.push_back(32'(v.fire));
         tick();
      end
      check_end($sformatf("vec%0d", k), v.hi, v.bsy, v.trg, v.lst);
   endtask

   initial begin
      //        en    vt    mask   maj   win    wid    dead    ch_a,t_a ch_b,t_b ch_c,t_c fire hi bsy trg lst
      vecs[0]  = '{1'b1, 1'b0, 8'h01, 4'd1, 8'd4, 8'd3, 16'd0,  0, 2,  0,-1,  0,-1,  5, 3, 3, 1, 0};
      vecs[1]  = '{1'b1, 1'b0, 8'h07, 4'd2, 8'd5, 8'd1, 16'd0,  0, 2,  2, 6,  0,-1,  9, 1, 1, 1, 0};
      vecs[2]  = '{1'b1, 1'b0, 8'h07, 4'd2, 8'd5, 8'd1, 16'd0,  0, 2,  2, 8,  0,-1, -1, 0, 0, 0, 0};
      vecs[3]  = '{1'b1, 1'b0, 8'h07, 4'd2, 8'd5, 8'd1, 16'd0,  0, 2,  2, 7,  0,-1, -1, 0, 0, 0, 0};
      vecs[4]  = '{1'b1, 1'b0, 8'h01, 4'd1, 8'd4, 8'd1, 16'd0,  1, 2,  0,-1,  0,-1, -1, 0, 0, 0, 0};
      vecs[5]  = '{1'b1, 1'b0, 8'hFF, 4'd0, 8'd4, 8'd1, 16'd0,  0, 2,  0,-1,  0,-1, -1, 0, 0, 0, 0};
      vecs[6]  = '{1'b1, 1'b0, 8'h01, 4'd2, 8'd4, 8'd1, 16'd0,  0, 2,  1, 2,  0,-1, -1, 0, 0, 0, 0};
      vecs[7]  = '{1'b1, 1'b1, 8'h01, 4'd1, 8'd4, 8'd1, 16'd0,  0, 2,  0,-1,  0,-1, -1, 0, 0, 0, 1};
      vecs[8]  = '{1'b1, 1'b0, 8'h01, 4'd1, 8'd0, 8'd0, 16'd0,  0, 2,  0,-1,  0,-1,  5, 1, 1, 1, 0};
      vecs[9]  = '{1'b1, 1'b0, 8'h03, 4'd2, 8'd1, 8'd4, 16'd0,  0, 3,  1, 3,  0,-1,  6, 4, 4, 1, 0};
      vecs[10] = '{1'b1, 1'b0, 8'h01, 4'd1, 8'd4, 8'd2, 16'd5,  0, 2,  0,-1,  0,-1,  5, 2, 7, 1, 0};
      vecs[11] = '{1'b1, 1'b0, 8'hF0, 4'd2, 8'd3, 8'd1, 16'd0,  4, 2,  4, 4,  7, 6,  9, 1, 1, 1, 0};
      vecs[12] = '{1'b1, 1'b0, 8'h01, 4'd1, 8'd8, 8'd1, 16'd0,  0, 2,  0,-1,  0,-1,  5, 1, 1, 1, 0};
      vecs[13] = '{1'b0, 1'b0, 8'h01, 4'd1, 8'd4, 8'd1, 16'd0,  0, 2,  0,-1,  0,-1, -1, 0, 0, 0, 0};

      for (int k = 0; k < 14; k++) run_vec(k);

      // veto: three separate coincidences, each counted lost exactly once
      do_reset(1'b0);
      config_set(8'h01, 4'd1, 8'd4, 8'd1, 16'd0);
      veto = 1'b1;
      for (int c = 0; c < 35; c++) begin
         ch_in = (c == 2 || c == 12 || c == 22) ? 8'h01 : 8'h00;
         tick();
      end
      check_end("veto", 0, 0, 0, 3);

      // dead time: pulses every 4 cycles, triggers every out_width + deadtime = 12 cycles
      do_reset(1'b0);
      config_set(8'h01, 4'd1, 8'd1, 8'd2, 16'd10);
      for (int c = 0; c < 56; c++) begin
         ch_in = (c < 40 && c % 4 == 0) ? 8'h01 : 8'h00;
         if (c < 40 && c % 12 == 0) exp_q.push_back(32'(c + 3));
         tick();
      end
      check_end("dead", 8, 48, 4, 0);

      // level held across reset release and for 50 cycles: one 1-cycle pulse
      do_reset(1'b1);
      config_set(8'h01, 4'd1, 8'd0, 8'd0, 16'd0);
      exp_q.push_back(32'd3);
      for (int c = 0; c < 60; c++) begin
         ch_in = (c < 50) ? 8'h01 : 8'h00;
         tick();
      end
      check_end("held", 1, 1, 1, 0);

      // count_clear on the same edge as an accepted trigger
      do_reset(1'b0);
      config_set(8'h01, 4'd1, 8'd1, 8'd1, 16'd0);
      for (int c = 0; c < 25; c++) begin
         ch_in = (c == 2 || c == 10 || c == 16) ? 8'h01 : 8'h00;
         if (c == 2 || c == 10 || c == 16) exp_q.push_back(32'(c + 3));
         count_clear = (c == 13);
         if (c == 11) chk("clear_before", 32'(trig_count), 1);
         if (c == 17) chk("clear_after", 32'(trig_count), 0);
         tick();
      end
      check_end("clear", 3, 3, 1, 0);

      // saturation of the narrow trigger counter
      do_reset(1'b0);
      config_set(8'h01, 4'd1, 8'd1, 8'd1, 16'd0);
      for (int c = 0; c < 70; c++) begin
         ch_in = (c < 60 && c % 3 == 0) ? 8'h01 : 8'h00;
         if (c < 60 && c % 3 == 0) exp_q.push_back(32'(c + 3));
         tick();
      end
      check_end("sat", 20, 20, 15, 0);

      // reset in the middle of a pulse truncates it immediately
      do_reset(1'b0);
      config_set(8'h01, 4'd1, 8'd4, 8'd8, 16'd0);
      for (int c = 0; c < 7; c++) begin
         ch_in = (c == 2) ? 8'h01 : 8'h00;
         if (c == 2) exp_q.push_back(32'd5);
         tick();
      end
      chk("midfire_trig_out", 32'(trig_out), 1);
      chk("midfire_trig_count", 32'(trig_count), 1);
      chk("midfire_sb_empty", 32'(exp_q.size()), 0);
      #2;
      do_reset(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nim_trigger_logic.md
Name: nim_trigger_logic

Overview:
Downstream stage of the per-channel NIM input conditioners. Takes the N conditioned trigger lines, forms a programmable majority coincidence within a cycle window, and gates it with veto/enable. It emits one fixed-width trigger pulse followed by a programmable dead time, and keeps accepted/lost trigger counters for the control registers.

Parameters:
N_CH, 8, number of conditioned input channels
CNT_W, 32, width of trigger counters

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
ch_in  input  N_CH  conditioned trigger lines from per-channel input stages (clk domain)
ch_mask  input  N_CH  1 = channel participates in coincidence
majority  input  4  number of masked channels required; 0 = logic disabled
window  input  8  coincidence window in cycles; 0 treated as 1
out_width  input  8  trigger pulse width in cycles; 0 treated as 1
deadtime  input  16  cycles blocked after pulse ends; 0 = none
veto  input  1  level veto; blocks triggers while high
enable  input  1  0 = no triggers, no counting, hit timers held at 0
count_clear  input  1  synchronous clear of both counters
trig_out  output  1  registered trigger pulse
busy  output  1  high during FIRE and DEAD
trig_count  output  CNT_W  accepted triggers, saturating
lost_count  output  CNT_W  coincidences rejected by veto, saturating

Behaviour:
- Reset is asynchronous and active-high. While reset is high, and immediately on assertion:
  - trig_out=0, busy=0, state=IDLE.
  - All hit timers, edge registers and counters = 0.
- Reset mid-pulse truncates the pulse at once.
- A ch_in that is held high across reset release counts as a rising edge.
- Edge detect: two registers per channel, d1<=ch_in, d2<=d1; edge=d1&~d2. Only rising edges count; a held level does not retrigger.
- Hit timer per channel, 8 bits:
  - Loaded with window_eff on edge.
  - Otherwise decrements to 0 and stops there.
  - active[i]=(timer!=0).
  - An edge while active reloads the timer (extends the window).
- coinc = (majority!=0) && popcount(active & ch_mask) >= majority, evaluated combinationally.
- majority > popcount(ch_mask) never fires and is not an error.
- FSM states are IDLE, FIRE and DEAD.
- IDLE:
  - If enable && coinc && !veto: go to FIRE, set trig_out<=1, width counter<=out_width_eff-1, trig_count++, all hit timers cleared.
  - Else if enable && coinc && veto: stay IDLE, lost_count++, all hit timers cleared, so a single coincidence is counted once.
- FIRE:
  - trig_out stays high for exactly out_width_eff cycles.
  - Then go to DEAD with counter<=deadtime-1, or directly to IDLE if deadtime=0.
- DEAD: busy=1, trig_out=0. Return to IDLE after deadtime cycles.
- Edges arriving in FIRE/DEAD still load timers. A coincidence still within its window when IDLE is re-entered fires on that cycle. Coincidences during busy are not counted as lost.
- Latency: ch_in first sampled high at edge E0 (majority=1, mask=1, idle, no veto) → trig_out high from edge E0+3.
- Back-to-back minimum spacing: out_width_eff + deadtime cycles.
- veto and enable are level-sensitive and do not affect a pulse already in FIRE. Dropping enable in FIRE/DEAD lets the sequence finish.
- Counters:
  - Saturate at all-ones.
  - count_clear sets both counters to 0 and wins over a simultaneous increment.
- Config inputs are used live. A window change affects only subsequently loaded timers. out_width/deadtime are sampled at the FIRE/DEAD entry.

Test Plan:
- Basic single channel: mask=0x01, majority=1, window=4, out_width=3, deadtime=0; pulse ch_in[0] 1 cycle → trig_out high exactly 3 cycles starting E0+3; trig_count=1.
- 2-of-3 coincidence: mask=0x07, majority=2, window=5. ch0 edge at t, ch2 edge at t+4 → one trigger. Repeat with ch2 at t+6 → no trigger, trig_count unchanged.
- Veto: majority=1, veto=1, 3 separate single-cycle ch0 pulses 10 cycles apart → trig_out never high; lost_count=3, trig_count=0.
- Deadtime: out_width=2, deadtime=10, ch0 pulses every 4 cycles (window=1) for 40 cycles → triggers spaced exactly 12 cycles apart; busy high 12 cycles per trigger.
- Held level, zero config, and masking:
  - ch_in[0] held high 50 cycles, out_width=0, window=0 → exactly one 1-cycle pulse.
  - Masked channel ch_in[1] pulsed with mask=0x01 → no trigger.
  - majority=0 → no trigger.
- Reset and counters:
  - Assert reset mid-FIRE → trig_out=0 in the same cycle, counters 0.
  - Preload trig_count to all-ones via repeated triggers in sim or force → stays saturated.
  - count_clear coincident with a trigger → trig_count=0.
